// File: rtl/tick_pwm_pkg.sv
// Shared types and reset defaults for the tick-driven PWM generator.
package tick_pwm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_PERIOD = 2;
    localparam int unsigned DEF_DUTY   = 1;

endpackage

// File: rtl/tick_pwm_cfg_stage.sv
// One-deep staging register for period/duty updates with valid/ready intake
// and an apply strobe that fires when the parent opens an apply window.
module tick_pwm_cfg_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_cfg_valid,
    input  logic [WIDTH-1:0] i_cfg_period,
    input  logic [WIDTH-1:0] i_cfg_duty,
    input  logic             i_apply_ok,
    output logic             o_cfg_ready,
    output logic [WIDTH-1:0] o_stg_period,
    output logic [WIDTH-1:0] o_stg_duty,
    output logic             o_apply
);
    import tick_pwm_pkg::*;

    logic             full_q, full_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;

    // Handshake: a transfer happens on any rising edge where i_cfg_valid and
    // o_cfg_ready are both 1; ready is simply "staging empty".
    assign o_cfg_ready  = ~full_q;
    assign o_apply      = full_q & i_apply_ok;
    assign o_stg_period = period_q;
    assign o_stg_duty   = duty_q;

    always_comb begin
        full_d   = full_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (o_apply) begin
            full_d = 1'b0;
        end else if (i_cfg_valid && !full_q) begin
            full_d   = 1'b1;
            period_d = i_cfg_period;
            duty_d   = i_cfg_duty;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q   <= 1'b0;
            period_q <= '0;
            duty_q   <= '0;
        end else begin
            full_q   <= full_d;
            period_q <= period_d;
            duty_q   <= duty_d;
        end
    end

endmodule

// File: rtl/tick_pwm_gen.sv
// PWM generator clocked by clk and advanced by a one-cycle tick enable;
// period/duty are counted in ticks and updated only at period boundaries.
module tick_pwm_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEF_PERIOD = tick_pwm_pkg::DEF_PERIOD,
    parameter int unsigned DEF_DUTY   = tick_pwm_pkg::DEF_DUTY
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_tick,
    input  logic                 i_enable,
    input  logic                 i_cfg_valid,
    input  logic [WIDTH-1:0]     i_cfg_period,
    input  logic [WIDTH-1:0]     i_cfg_duty,
    output logic                 o_cfg_ready,
    output logic                 o_pwm,
    output logic                 o_period_end,
    output logic [WIDTH-1:0]     o_count,
    output tick_pwm_pkg::state_t o_dbg_state
);
    import tick_pwm_pkg::*;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             pend_q, pend_d;
    logic             boundary, apply_ok, apply;
    logic [WIDTH-1:0] stg_period, stg_duty;

    // A boundary only exists while the generator keeps running through it.
    assign boundary = (state_q == ST_RUN) && i_enable && i_tick && (count_q == period_q);
    assign apply_ok = (state_q == ST_IDLE) || boundary;

    tick_pwm_cfg_stage #(.WIDTH(WIDTH)) u_cfg_stage (
        .clk          (clk),
        .resetn       (resetn),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_period (i_cfg_period),
        .i_cfg_duty   (i_cfg_duty),
        .i_apply_ok   (apply_ok),
        .o_cfg_ready  (o_cfg_ready),
        .o_stg_period (stg_period),
        .o_stg_duty   (stg_duty),
        .o_apply      (apply)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pwm_d    = pwm_q;
        pend_d   = 1'b0;
        period_d = apply ? stg_period : period_q;
        duty_d   = apply ? stg_duty : duty_q;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                pwm_d   = 1'b0;
                if (i_enable) begin
                    state_d = ST_RUN;
                    pwm_d   = (duty_d != '0);
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    pwm_d   = 1'b0;
                end else if (i_tick) begin
                    count_d = boundary ? '0 : count_q + 1'b1;
                    // The sample after a wrap already uses a freshly applied duty.
                    pwm_d   = ({1'b0, count_d} < {1'b0, duty_d});
                    pend_d  = boundary;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= WIDTH'(DEF_PERIOD);
            duty_q   <= WIDTH'(DEF_DUTY);
            pwm_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            pend_q   <= pend_d;
        end
    end

    assign o_pwm        = pwm_q;
    assign o_period_end = pend_q;
    assign o_count      = count_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Bench for tick_pwm_gen: hand-derived vector table, directed corner
// sequences and randomized traffic against a tick-level reference model.
module tb_tick_pwm_gen;
    import tick_pwm_pkg::*;

    localparam int W  = 8;
    localparam int EW = W + 4;  // {ready, pwm, period_end, running, count}

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         i_tick = 1'b0;
    logic         i_enable = 1'b0;
    logic         i_cfg_valid = 1'b0;
    logic [W-1:0] i_cfg_period = '0;
    logic [W-1:0] i_cfg_duty = '0;
    logic         o_cfg_ready;
    logic         o_pwm;
    logic         o_period_end;
    logic [W-1:0] o_count;
    state_t       o_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model state, in plain integers.
    bit m_run, m_staged, m_pwm, m_pend;
    int m_pos, m_period, m_duty, m_sp, m_sd;

    typedef struct {
        bit            tk;
        bit            en;
        bit            v;
        logic [W-1:0]  p;
        logic [W-1:0]  d;
        logic [EW-1:0] exp;
    } vec_t;
    vec_t tbl[22];

    tick_pwm_gen #(.WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_tick       (i_tick),
        .i_enable     (i_enable),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_period (i_cfg_period),
        .i_cfg_duty   (i_cfg_duty),
        .o_cfg_ready  (o_cfg_ready),
        .o_pwm        (o_pwm),
        .o_period_end (o_period_end),
        .o_count      (o_count),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic void model_reset();
        m_run = 0; m_staged = 0; m_pwm = 0; m_pend = 0;
        m_pos = 0; m_period = DEF_PERIOD; m_duty = DEF_DUTY;
        m_sp = 0; m_sd = 0;
    endfunction

    // One clock edge: a running period ends when the last tick position is
    // ticked past; pending settings take effect at that wrap or at once when idle.
    function automatic void model_step(bit tk, bit en, bit v, int p, int d);
        bit take   = v && !m_staged;
        bit wraps  = m_run && en && tk && (m_pos == m_period);
        bit adopt  = m_staged && (!m_run || wraps);
        int period = adopt ? m_sp : m_period;
        int duty   = adopt ? m_sd : m_duty;
        m_pend = wraps;
        if (!m_run) begin
            m_pos = 0;
            m_run = en;
            m_pwm = en && (duty > 0);
        end else if (!en) begin
            m_run = 0;
            m_pos = 0;
            m_pwm = 0;
        end else if (tk) begin
            m_pos = wraps ? 0 : m_pos + 1;
            m_pwm = (m_pos < duty);
        end
        m_period = period;
        m_duty   = duty;
        if (adopt) m_staged = 0;
        if (take) begin
            m_staged = 1; m_sp = p; m_sd = d;
        end
    endfunction

    function automatic logic [EW-1:0] model_out();
        return {!m_staged, m_pwm, m_pend, m_run, W'(m_pos)};
    endfunction

    function automatic logic [EW-1:0] dut_out();
        return {o_cfg_ready, o_pwm, o_period_end, (o_dbg_state == ST_RUN), o_count};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit tk, input bit en, input bit v,
                         input logic [W-1:0] p, input logic [W-1:0] d);
        i_tick = tk; i_enable = en; i_cfg_valid = v; i_cfg_period = p; i_cfg_duty = d;
        @(posedge clk);
        model_step(tk, en, v, int'(p), int'(d));
        exp_q.push_back(model_out());
        @(negedge clk);
        check("model", dut_out(), exp_q.pop_front());
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1, 1, 0, '0, '0);
    endtask

    function automatic vec_t mk(bit tk, bit v, int p, int d, bit rdy, bit pwm, bit pend, int cnt);
        vec_t r;
        r.tk = tk; r.en = 1'b1; r.v = v; r.p = W'(p); r.d = W'(d);
        r.exp = {rdy, pwm, pend, 1'b1, W'(cnt)};
        return r;
    endfunction

    initial begin
        // Defaults, tick every 3rd clock, then period 4 / duty 3 offered at count 1.
        tbl[0]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
        tbl[4]  = mk(1, 0, 0, 0, 1, 0, 0, 2);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 2);
        tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 2);
        tbl[7]  = mk(1, 0, 0, 0, 1, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 1, 0, 0, 1);
        tbl[11] = mk(0, 1, 4, 3, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 2);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 2);
        tbl[16] = mk(1, 0, 0, 0, 1, 1, 1, 0);
        tbl[17] = mk(1, 0, 0, 0, 1, 1, 0, 1);
        tbl[18] = mk(1, 0, 0, 0, 1, 1, 0, 2);
        tbl[19] = mk(1, 0, 0, 0, 1, 0, 0, 3);
        tbl[20] = mk(1, 0, 0, 0, 1, 0, 0, 4);
        tbl[21] = mk(1, 0, 0, 0, 1, 1, 1, 0);

        // ---------------- reset ----------------
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), {1'b1, 1'b0, 1'b0, 1'b0, W'(0)});
        resetn = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].tk, tbl[i].en, tbl[i].v, tbl[i].p, tbl[i].d);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // ---------------- duty 0, then duty above period ----------------
        cycle(0, 1, 1, 8'd4, 8'd0);
        ticks(5);
        for (int k = 0; k < 10; k++) begin
            ticks(1);
            check("duty0_low", EW'(o_pwm), EW'(0));
        end
        cycle(0, 1, 1, 8'd4, 8'd9);
        ticks(5);
        for (int k = 0; k < 10; k++) begin
            ticks(1);
            check("duty9_high", EW'(o_pwm), EW'(1));
        end

        // ---------------- period 0, tick every clock ----------------
        cycle(0, 1, 1, 8'd0, 8'd1);
        ticks(6);
        for (int k = 0; k < 8; k++) begin
            ticks(1);
            check("p0_end", EW'(o_period_end), EW'(1));
            check("p0_pwm", EW'(o_pwm), EW'(1));
        end

        // ---------------- disable mid-period, config while idle ----------------
        cycle(0, 1, 1, 8'd4, 8'd3);
        ticks(2);
        for (int k = 0; k < 10 && m_pos != 2; k++) ticks(1);
        cycle(0, 0, 0, '0, '0);
        check("dis_count", EW'(o_count), EW'(0));
        check("dis_pwm", EW'(o_pwm), EW'(0));
        check("dis_state", EW'(o_dbg_state == ST_RUN), EW'(0));
        cycle(1, 0, 1, 8'd6, 8'd2);
        check("idle_cap_ready", EW'(o_cfg_ready), EW'(0));
        cycle(1, 0, 0, '0, '0);
        check("idle_apply_ready", EW'(o_cfg_ready), EW'(1));
        cycle(0, 1, 0, '0, '0);
        ticks(9);

        // ---------------- reset with a staged config pending ----------------
        cycle(0, 1, 1, 8'd7, 8'd5);
        #2 resetn = 1'b0;
        #1 check("async_reset", dut_out(), {1'b1, 1'b0, 1'b0, 1'b0, W'(0)});
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].tk, tbl[i].en, tbl[i].v, tbl[i].p, tbl[i].d);
            check($sformatf("defaults[%0d]", i), dut_out(), tbl[i].exp);
        end

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < 3000; k++) begin
            bit tk = ($urandom_range(0, 2) == 0) || (k % 500 < 60);
            bit en = ($urandom_range(0, 19) != 0);
            bit v  = ($urandom_range(0, 5) == 0);
            logic [W-1:0] p = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 6));
            logic [W-1:0] d = W'($urandom_range(0, 8));
            cycle(tk, en, v, p, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
